// File: rtl/aec_expr_tx_pkg.sv
// aec_pkg: token codes, ASCII constants and FSM state encoding shared by the AEC transmitter files.
`default_nettype none
package aec_pkg;

  localparam logic [4:0] CODE_LPAR = 5'd16;
  localparam logic [4:0] CODE_RPAR = 5'd17;
  localparam logic [4:0] CODE_MUL  = 5'd18;
  localparam logic [4:0] CODE_ADD  = 5'd19;
  localparam logic [4:0] CODE_SUB  = 5'd20;
  localparam logic [4:0] CODE_EQ   = 5'd21;
  localparam logic [4:0] CODE_MAX  = CODE_SUB;

  localparam logic [7:0] ASCII_EQ  = 8'd61;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SEND_FIRST = 3'd1,
    ST_SEND       = 3'd2,
    ST_SEND_EQ    = 3'd3,
    ST_WAIT_RES   = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/aec_expr_tx_if.sv
// aec_expr_tx_if: host-load, AEC ascii/ready link and result signals of the expression transmitter.
`default_nettype none
interface aec_expr_tx_if;
  logic       load_we;
  logic [4:0] load_code;
  logic       start;
  logic       busy;
  logic       ready;
  logic [7:0] ascii_out;
  logic       valid_in;
  logic [6:0] result_in;
  logic [6:0] result_out;
  logic       done;
  logic       err;
  logic       timeout;

  // master = host sequencer plus the AEC side; slave = the transmitter itself
  modport master (
    output load_we, load_code, start, valid_in, result_in,
    input  busy, ready, ascii_out, result_out, done, err, timeout
  );

  modport slave (
    input  load_we, load_code, start, valid_in, result_in,
    output busy, ready, ascii_out, result_out, done, err, timeout
  );
endinterface
`default_nettype wire

// File: rtl/aec_expr_tx_code2ascii.sv
// aec_code2ascii: combinational token code to ASCII character; unknown codes map to 8'd0.
`default_nettype none
module aec_code2ascii
  import aec_pkg::*;
(
  input  logic [4:0] code,
  output logic [7:0] ascii
);

  always_comb begin
    ascii = 8'd0;
    if (code < 5'd10)       ascii = 8'd48 + {3'b000, code};
    else if (code < 5'd16)  ascii = 8'd87 + {3'b000, code};
    else begin
      case (code)
        CODE_LPAR: ascii = 8'd40;
        CODE_RPAR: ascii = 8'd41;
        CODE_MUL:  ascii = 8'd42;
        CODE_ADD:  ascii = 8'd43;
        CODE_SUB:  ascii = 8'd45;
        CODE_EQ:   ascii = ASCII_EQ;
        default:   ascii = 8'd0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/aec_expr_tx.sv
// aec_expr_tx: buffers token codes, streams them as ASCII to AEC with a trailing '=', then captures the result.
// Optional macro AEC_TX_TIMEOUT_EN bounds the result wait to TIMEOUT_CYC cycles.
`default_nettype none
module aec_expr_tx
  import aec_pkg::*;
#(
  parameter int MAX_LEN     = 15,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic         clk,
  input  logic         rst,
  aec_expr_tx_if.slave bus
);

  localparam int CNT_W = $clog2(MAX_LEN + 1);
  localparam int PTR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  state_t           state, state_nxt;
  logic [4:0]       tok_buf [MAX_LEN];
  logic [CNT_W-1:0] cnt;
  logic [PTR_W-1:0] rd_ptr, rd_nxt;
  logic             start_ok, start_empty, wr_ok, wr_bad, last_tok, got_res, expire;
  logic [4:0]       sel_code;
  logic [7:0]       sel_ascii, ascii_nxt;

  logic             ready_q, busy_q, done_q, err_q;
  logic [7:0]       ascii_q;
  logic [6:0]       result_q;

  // start has priority over a same-cycle load: the token is dropped silently
  always_comb begin
    start_ok    = (state == ST_IDLE) && bus.start && (cnt != '0);
    start_empty = (state == ST_IDLE) && bus.start && (cnt == '0);
    wr_ok       = (state == ST_IDLE) && bus.load_we && !bus.start &&
                  (bus.load_code <= CODE_MAX) && (cnt != CNT_W'(MAX_LEN));
    wr_bad      = (state == ST_IDLE) && bus.load_we && !bus.start && !wr_ok;
    last_tok    = (CNT_W'(rd_ptr) == cnt - CNT_W'(1));
    got_res     = (state == ST_WAIT_RES) && bus.valid_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      rd_ptr <= '0;
    end else begin
      state  <= state_nxt;
      rd_ptr <= rd_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rd_nxt    = rd_ptr;
    case (state)
      ST_IDLE: begin
        if (start_ok) begin
          state_nxt = ST_SEND_FIRST;
          rd_nxt    = '0;
        end
      end
      ST_SEND_FIRST, ST_SEND: begin
        if (last_tok) begin
          state_nxt = ST_SEND_EQ;
        end else begin
          state_nxt = ST_SEND;
          rd_nxt    = rd_ptr + 1'b1;
        end
      end
      ST_SEND_EQ:  state_nxt = ST_WAIT_RES;
      ST_WAIT_RES: if (got_res || expire) state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so the character lines up with its state
  always_comb begin
    sel_code  = tok_buf[rd_nxt];
    ascii_nxt = 8'd0;
    if ((state_nxt == ST_SEND_FIRST) || (state_nxt == ST_SEND)) ascii_nxt = sel_ascii;
    else if (state_nxt == ST_SEND_EQ)                            ascii_nxt = ASCII_EQ;
  end

  aec_code2ascii u_enc (
    .code  (sel_code),
    .ascii (sel_ascii)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      ready_q  <= 1'b0;
      ascii_q  <= 8'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      result_q <= 7'd0;
      for (int i = 0; i < MAX_LEN; i++) tok_buf[i] <= 5'd0;
    end else begin
      ready_q <= (state_nxt == ST_SEND_FIRST);
      ascii_q <= ascii_nxt;
      busy_q  <= (state_nxt != ST_IDLE);
      done_q  <= got_res;
      if (wr_ok) begin
        tok_buf[PTR_W'(cnt)] <= bus.load_code;
        cnt                  <= cnt + 1'b1;
      end
      if (got_res || expire) cnt <= '0;
      if (got_res)     result_q <= bus.result_in;
      else if (expire) result_q <= 7'h7F;
      if (start_ok)                               err_q <= 1'b0;
      else if (wr_bad || start_empty || expire)   err_q <= 1'b1;
    end
  end

`ifdef AEC_TX_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt;
  logic             timeout_q;

  // valid_in on the expiry cycle takes precedence over the timeout
  assign expire = (state == ST_WAIT_RES) && !bus.valid_in &&
                  (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt   <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= expire;
      if (state == ST_WAIT_RES) tmo_cnt <= tmo_cnt + 1'b1;
      else                      tmo_cnt <= '0;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign expire      = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  assign bus.ready      = ready_q;
  assign bus.ascii_out  = ascii_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.result_out = result_q;

endmodule
`default_nettype wire

// File: tb/tb_aec_expr_tx.sv
// tb_aec_expr_tx: directed-vector bench for the AEC expression transmitter.
`default_nettype none
module tb_aec_expr_tx;

`ifdef AEC_TX_TIMEOUT_EN
  localparam int TCYC = 8;
`else
  localparam int TCYC = 255;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  aec_expr_tx_if bus ();

  aec_expr_tx #(
    .MAX_LEN     (15),
    .TIMEOUT_CYC (TCYC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic load_tok(input logic [4:0] code);
    bus.load_we   = 1'b1;
    bus.load_code = code;
    tick();
    bus.load_we   = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic give_result(input logic [6:0] r);
    bus.valid_in  = 1'b1;
    bus.result_in = r;
    tick();
    bus.valid_in  = 1'b0;
  endtask

  task automatic test_reset();
    bus.load_we = 0; bus.load_code = 0; bus.start = 0; bus.valid_in = 0; bus.result_in = 0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    total_cnt++;
    if ({bus.busy, bus.ready, bus.ascii_out, bus.done, bus.err, bus.timeout, bus.result_out} !== 20'd0)
      $display("FAIL reset_outputs: got busy=%b ready=%b ascii=%0d done=%b err=%b timeout=%b result=%0d, expected all 0",
               bus.busy, bus.ready, bus.ascii_out, bus.done, bus.err, bus.timeout, bus.result_out);
    else pass_cnt++;
  endtask

  task automatic test_add();
    logic [7:0] exp_a [3] = '{8'd43, 8'd50, 8'd61};
    load_tok(5'd1); load_tok(5'd19); load_tok(5'd2);
    pulse_start();
    total_cnt++;
    if ({bus.ready, bus.busy, bus.ascii_out} !== {1'b1, 1'b1, 8'd49})
      $display("FAIL add_first: got ready=%b busy=%b ascii=%0d, expected ready=1 busy=1 ascii=49", bus.ready, bus.busy, bus.ascii_out);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      tick();
      total_cnt++;
      if ({bus.ready, bus.ascii_out} !== {1'b0, exp_a[i]})
        $display("FAIL add_char%0d: got ready=%b ascii=%0d, expected ready=0 ascii=%0d", i + 1, bus.ready, bus.ascii_out, exp_a[i]);
      else pass_cnt++;
    end
    tick();
    total_cnt++;
    if ({bus.busy, bus.ascii_out} !== {1'b1, 8'd0})
      $display("FAIL add_wait: got busy=%b ascii=%0d, expected busy=1 ascii=0", bus.busy, bus.ascii_out);
    else pass_cnt++;
    give_result(7'd3);
    total_cnt++;
    if ({bus.done, bus.busy, bus.result_out} !== {1'b1, 1'b0, 7'd3})
      $display("FAIL add_result: got done=%b busy=%b result=%0d, expected done=1 busy=0 result=3", bus.done, bus.busy, bus.result_out);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({bus.done, bus.err, bus.result_out} !== {1'b0, 1'b0, 7'd3})
      $display("FAIL add_after: got done=%b err=%b result=%0d, expected done=0 err=0 result=3", bus.done, bus.err, bus.result_out);
    else pass_cnt++;
  endtask

  task automatic test_paren();
    logic [4:0] toks [7] = '{5'd16, 5'd3, 5'd19, 5'd4, 5'd17, 5'd18, 5'd2};
    logic [7:0] exp_p [7] = '{8'd51, 8'd43, 8'd52, 8'd41, 8'd42, 8'd50, 8'd61};
    for (int i = 0; i < 7; i++) load_tok(toks[i]);
    pulse_start();
    total_cnt++;
    if ({bus.ready, bus.ascii_out} !== {1'b1, 8'd40})
      $display("FAIL paren_first: got ready=%b ascii=%0d, expected ready=1 ascii=40", bus.ready, bus.ascii_out);
    else pass_cnt++;
    // valid_in during the stream must be ignored
    for (int i = 0; i < 7; i++) begin
      bus.valid_in  = (i < 4);
      bus.result_in = 7'd99;
      tick();
      total_cnt++;
      if ({bus.done, bus.ready, bus.ascii_out} !== {1'b0, 1'b0, exp_p[i]})
        $display("FAIL paren_char%0d: got done=%b ready=%b ascii=%0d, expected done=0 ready=0 ascii=%0d",
                 i + 1, bus.done, bus.ready, bus.ascii_out, exp_p[i]);
      else pass_cnt++;
    end
    bus.valid_in = 1'b0;
    tick();
    give_result(7'd14);
    total_cnt++;
    if ({bus.done, bus.result_out} !== {1'b1, 7'd14})
      $display("FAIL paren_result: got done=%b result=%0d, expected done=1 result=14", bus.done, bus.result_out);
    else pass_cnt++;
  endtask

  task automatic test_bad_code();
    load_tok(5'd7);
    total_cnt++;
    if (bus.err !== 1'b0) $display("FAIL bad_good_tok: got err=%b, expected err=0", bus.err);
    else pass_cnt++;
    load_tok(5'd21);
    total_cnt++;
    if (bus.err !== 1'b1) $display("FAIL bad_code_err: got err=%b, expected err=1", bus.err);
    else pass_cnt++;
    bus.start = 1'b1; bus.load_we = 1'b1; bus.load_code = 5'd9;
    tick();
    bus.start = 1'b0; bus.load_we = 1'b0;
    total_cnt++;
    if ({bus.ready, bus.err, bus.ascii_out} !== {1'b1, 1'b0, 8'd55})
      $display("FAIL bad_start_first: got ready=%b err=%b ascii=%0d, expected ready=1 err=0 ascii=55", bus.ready, bus.err, bus.ascii_out);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (bus.ascii_out !== 8'd61) $display("FAIL bad_start_eq: got ascii=%0d, expected 61", bus.ascii_out);
    else pass_cnt++;
    tick();
    give_result(7'd7);
    total_cnt++;
    if ({bus.done, bus.result_out} !== {1'b1, 7'd7})
      $display("FAIL bad_result: got done=%b result=%0d, expected done=1 result=7", bus.done, bus.result_out);
    else pass_cnt++;
  endtask

  task automatic test_overflow();
    logic [7:0] exp_o [15] = '{8'd49, 8'd50, 8'd51, 8'd52, 8'd53, 8'd54, 8'd55, 8'd56, 8'd57,
                               8'd97, 8'd98, 8'd99, 8'd100, 8'd101, 8'd61};
    logic bad = 1'b0;
    for (int c = 0; c < 15; c++) load_tok(5'(c));
    total_cnt++;
    if (bus.err !== 1'b0) $display("FAIL ovf_full_err: got err=%b, expected err=0", bus.err);
    else pass_cnt++;
    load_tok(5'd20);
    total_cnt++;
    if (bus.err !== 1'b1) $display("FAIL ovf_16th_err: got err=%b, expected err=1", bus.err);
    else pass_cnt++;
    pulse_start();
    total_cnt++;
    if ({bus.ready, bus.err, bus.ascii_out} !== {1'b1, 1'b0, 8'd48})
      $display("FAIL ovf_first: got ready=%b err=%b ascii=%0d, expected ready=1 err=0 ascii=48", bus.ready, bus.err, bus.ascii_out);
    else pass_cnt++;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus.ascii_out !== exp_o[i]) begin
        if (!bad) $display("FAIL ovf_stream: char %0d got ascii=%0d, expected %0d", i + 1, bus.ascii_out, exp_o[i]);
        bad = 1'b1;
      end
    end
    total_cnt++;
    if (bad) $display("FAIL ovf_stream_total: got mismatching stream, expected 15 chars plus '='");
    else pass_cnt++;
    tick();
    total_cnt++;
    if (bus.ascii_out !== 8'd0) $display("FAIL ovf_after_eq: got ascii=%0d, expected 0", bus.ascii_out);
    else pass_cnt++;
    give_result(7'd0);
    pulse_start();
    total_cnt++;
    if ({bus.busy, bus.ready, bus.err} !== {1'b0, 1'b0, 1'b1})
      $display("FAIL empty_start: got busy=%b ready=%b err=%b, expected busy=0 ready=0 err=1", bus.busy, bus.ready, bus.err);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    load_tok(5'd1); load_tok(5'd19); load_tok(5'd2);
    pulse_start();
    tick();
    #2 rst = 1'b0;
    #1;
    total_cnt++;
    if ({bus.busy, bus.ready, bus.ascii_out} !== {1'b0, 1'b0, 8'd0})
      $display("FAIL rst_async: got busy=%b ready=%b ascii=%0d, expected all 0", bus.busy, bus.ready, bus.ascii_out);
    else pass_cnt++;
    tick();
    rst = 1'b1;
    tick();
    total_cnt++;
    if ({bus.err, bus.ascii_out} !== {1'b0, 8'd0})
      $display("FAIL rst_release: got err=%b ascii=%0d, expected err=0 ascii=0", bus.err, bus.ascii_out);
    else pass_cnt++;
    pulse_start();
    total_cnt++;
    if ({bus.busy, bus.err} !== {1'b0, 1'b1})
      $display("FAIL rst_cnt_cleared: got busy=%b err=%b, expected busy=0 err=1", bus.busy, bus.err);
    else pass_cnt++;
  endtask

`ifdef AEC_TX_TIMEOUT_EN
  task automatic test_timeout();
    logic early = 1'b0;
    load_tok(5'd5);
    pulse_start();
    total_cnt++;
    if ({bus.ready, bus.err, bus.ascii_out} !== {1'b1, 1'b0, 8'd53})
      $display("FAIL tmo_first: got ready=%b err=%b ascii=%0d, expected ready=1 err=0 ascii=53", bus.ready, bus.err, bus.ascii_out);
    else pass_cnt++;
    tick();
    tick();
    for (int k = 2; k <= 8; k++) begin
      tick();
      if (bus.timeout !== 1'b0) early = 1'b1;
    end
    total_cnt++;
    if (early) $display("FAIL tmo_early: got timeout=1 before expiry, expected 0");
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({bus.timeout, bus.err, bus.busy, bus.result_out} !== {1'b1, 1'b1, 1'b0, 7'h7F})
      $display("FAIL tmo_expire: got timeout=%b err=%b busy=%b result=%0h, expected timeout=1 err=1 busy=0 result=7f",
               bus.timeout, bus.err, bus.busy, bus.result_out);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (bus.timeout !== 1'b0) $display("FAIL tmo_pulse: got timeout=%b, expected 0", bus.timeout);
    else pass_cnt++;
  endtask
`else
  task automatic test_wait_forever();
    logic bad = 1'b0;
    load_tok(5'd5);
    pulse_start();
    total_cnt++;
    if ({bus.ready, bus.ascii_out} !== {1'b1, 8'd53})
      $display("FAIL wait_first: got ready=%b ascii=%0d, expected ready=1 ascii=53", bus.ready, bus.ascii_out);
    else pass_cnt++;
    tick();
    for (int k = 0; k < 40; k++) begin
      tick();
      if ({bus.busy, bus.timeout} !== 2'b10) bad = 1'b1;
    end
    total_cnt++;
    if (bad) $display("FAIL wait_hold: got busy drop or timeout, expected busy=1 timeout=0 throughout");
    else pass_cnt++;
    give_result(7'd9);
    total_cnt++;
    if ({bus.done, bus.result_out} !== {1'b1, 7'd9})
      $display("FAIL wait_result: got done=%b result=%0d, expected done=1 result=9", bus.done, bus.result_out);
    else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_paren();
    test_bad_code();
    test_overflow();
    test_reset_mid();
`ifdef AEC_TX_TIMEOUT_EN
    test_timeout();
`else
    test_wait_forever();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
